// File: rtl/flash_pkg.sv
// Shared definitions for the Flash bridge arbiter: FSM encoding, bridge
// direction codes and address width.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic FB_READ  = 1'b1;
  localparam logic FB_WRITE = 1'b0;
  localparam int   FB_AW    = 8;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/flash_rr_pick.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to the
// requester that did not own the previous burst.
module flash_rr_pick (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] pick,
  output logic       valid
);

  always_comb begin
    valid = |req;
    pick  = req;
    if (req == 2'b11) begin
      pick = last_owner ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one byte-wide Flash bridge between two requesters: round-robin grant,
// one bridge handshake per byte of a burst, watchdog abort on a hung bridge.
//
// state  | meaning
// IDLE   | no burst; sample req and latch the winner's burst
// ISSUE  | start the next byte, or finish when none remain
// WAIT   | bridge busy; watchdog running
// ACK    | byte complete; advance address, decrement remaining
// FINISH | report done/err, hand round-robin priority over
module flash_arbiter
  import flash_pkg::*;
#(
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               CLK_50MHZ,
  input  logic               RST,
  input  logic [1:0]         req,
  input  logic [1:0]         dir,
  input  logic [15:0]        addr,
  input  logic [2*LEN_W-1:0] len,
  input  logic [15:0]        wdata,
  output logic [1:0]         grant,
  output logic [1:0]         byte_ack,
  output logic [7:0]         rdata,
  output logic [1:0]         done,
  output logic [1:0]         err,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [7:0]         fb_wdata,
  output logic               fb_dir,
  output logic               fb_start,
  input  logic [7:0]         fb_rdata,
  input  logic               fb_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               owner_q, owner_d;
  logic               dir_q, dir_d;
  logic [FB_AW-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               abort_q, abort_d;
  logic               last_owner_q, last_owner_d;
  logic [7:0]         rd_cap_q, rd_cap_d;

  logic [1:0]         grant_q, grant_d;
  logic [1:0]         byte_ack_q, byte_ack_d;
  logic [7:0]         rdata_q, rdata_d;
  logic [1:0]         done_q, done_d;
  logic [1:0]         err_q, err_d;
  logic [FB_AW-1:0]   fb_addr_q, fb_addr_d;
  logic [7:0]         fb_wdata_q, fb_wdata_d;
  logic               fb_dir_q, fb_dir_d;
  logic               fb_start_q, fb_start_d;

  logic [1:0]         pick;
  logic               pick_valid;

  flash_rr_pick u_pick (
    .req        (req),
    .last_owner (last_owner_q),
    .pick       (pick),
    .valid      (pick_valid)
  );

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      dir_q        <= FB_READ;
      addr_q       <= '0;
      rem_q        <= '0;
      wd_q         <= '0;
      abort_q      <= 1'b0;
      last_owner_q <= 1'b1;
      rd_cap_q     <= '0;
      grant_q      <= '0;
      byte_ack_q   <= '0;
      rdata_q      <= '0;
      done_q       <= '0;
      err_q        <= '0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      fb_dir_q     <= FB_READ;
      fb_start_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      dir_q        <= dir_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
      abort_q      <= abort_d;
      last_owner_q <= last_owner_d;
      rd_cap_q     <= rd_cap_d;
      grant_q      <= grant_d;
      byte_ack_q   <= byte_ack_d;
      rdata_q      <= rdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_dir_q     <= fb_dir_d;
      fb_start_q   <= fb_start_d;
    end
  end

  // Next state and burst bookkeeping; the watchdog is a down-counter loaded
  // as each byte is issued, so the last WAIT cycle is the terminal count of 1.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dir_d        = dir_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    abort_d      = abort_q;
    last_owner_d = last_owner_q;
    rd_cap_d     = rd_cap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_d = pick[1];
          dir_d   = dir[pick[1]];
          addr_d  = pick[1] ? addr[15:8] : addr[7:0];
          rem_d   = pick[1] ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (rem_q == '0) begin
          state_d = ST_FINISH;
        end else begin
          wd_d    = WD_W'(TIMEOUT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // fb_done wins over a simultaneous watchdog expiry
        if (fb_done) begin
          if (dir_q == FB_READ) begin
            rd_cap_d = fb_rdata;
          end
          wd_d    = '0;
          state_d = ST_ACK;
        end else if (wd_q == WD_W'(1)) begin
          wd_d    = '0;
          abort_d = 1'b1;
          state_d = ST_FINISH;
        end else begin
          wd_d = wd_q - WD_W'(1);
        end
      end
      ST_ACK: begin
        addr_d  = addr_q + FB_AW'(1);
        rem_d   = rem_q - LEN_W'(1);
        state_d = ST_ISSUE;
      end
      ST_FINISH: begin
        last_owner_d = owner_q;
        abort_d      = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    grant_d    = grant_q;
    byte_ack_d = '0;
    rdata_d    = rdata_q;
    done_d     = '0;
    err_d      = '0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    fb_dir_d   = fb_dir_q;
    fb_start_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
        end
      end
      ST_ISSUE: begin
        if (rem_q != '0) begin
          fb_start_d = 1'b1;
          fb_addr_d  = addr_q;
          fb_dir_d   = dir_q;
          fb_wdata_d = owner_q ? wdata[15:8] : wdata[7:0];
        end
      end
      ST_ACK: begin
        byte_ack_d = owner_onehot(owner_q);
        if (dir_q == FB_READ) begin
          rdata_d = rd_cap_q;
        end
      end
      ST_FINISH: begin
        done_d  = owner_onehot(owner_q);
        err_d   = abort_q ? owner_onehot(owner_q) : 2'b00;
        grant_d = '0;
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign grant    = grant_q;
  assign byte_ack = byte_ack_q;
  assign rdata    = rdata_q;
  assign done     = done_q;
  assign err      = err_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign fb_dir   = fb_dir_q;
  assign fb_start = fb_start_q;

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a small behavioural Flash bridge that
// answers a read with {4'hA, addr[3:0]} after a fixed latency.
module tb_flash_arbiter;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 20;
  localparam int LAT     = 2;

  logic               CLK_50MHZ;
  logic               RST;
  logic [1:0]         req;
  logic [1:0]         dir;
  logic [15:0]        addr;
  logic [2*LEN_W-1:0] len;
  logic [15:0]        wdata;
  logic [1:0]         grant;
  logic [1:0]         byte_ack;
  logic [7:0]         rdata;
  logic [1:0]         done;
  logic [1:0]         err;
  logic [7:0]         fb_addr;
  logic [7:0]         fb_wdata;
  logic               fb_dir;
  logic               fb_start;
  logic [7:0]         fb_rdata;
  logic               fb_done;

  int n_cmp;
  int n_bad;
  int bridge_mode;  // 0 answer, 1 hang, 2 hang then answer far too late

  int          obs_starts, obs_acks, obs_done_at, obs_extra_done, obs_other_ack;
  logic [1:0]  obs_grant, obs_done, obs_err;
  logic        obs_fbdir;
  logic [7:0]  obs_fbaddr  [16];
  logic [7:0]  obs_fbwdata [16];
  logic [7:0]  obs_rdata   [16];

  flash_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK_50MHZ (CLK_50MHZ),
    .RST       (RST),
    .req       (req),
    .dir       (dir),
    .addr      (addr),
    .len       (len),
    .wdata     (wdata),
    .grant     (grant),
    .byte_ack  (byte_ack),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .fb_dir    (fb_dir),
    .fb_start  (fb_start),
    .fb_rdata  (fb_rdata),
    .fb_done   (fb_done)
  );

  initial begin
    CLK_50MHZ = 1'b0;
    forever #5 CLK_50MHZ = ~CLK_50MHZ;
  end

  initial begin
    fb_done  = 1'b0;
    fb_rdata = 8'h00;
    forever begin
      @(posedge CLK_50MHZ);
      #1;
      if (fb_start === 1'b1) begin
        if (bridge_mode == 0) begin
          repeat (LAT) @(posedge CLK_50MHZ);
          #1;
          fb_rdata = {4'hA, fb_addr[3:0]};
          fb_done  = 1'b1;
          @(posedge CLK_50MHZ);
          #1 fb_done = 1'b0;
        end else if (bridge_mode == 2) begin
          repeat (TIMEOUT + 6) @(posedge CLK_50MHZ);
          #1;
          fb_rdata = 8'hEE;
          fb_done  = 1'b1;
          @(posedge CLK_50MHZ);
          #1 fb_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got still running expected finished");
    $fatal(1);
  end

  task automatic run_burst(input int r, input logic rd, input logic [7:0] a,
                           input logic [LEN_W-1:0] l, input logic [7:0] w0,
                           input logic [7:0] w1);
    int cyc;
    bit fin;
    obs_starts = 0; obs_acks = 0; obs_done_at = -1;
    obs_extra_done = 0; obs_other_ack = 0;
    obs_grant = 2'b00; obs_done = 2'b00; obs_err = 2'b00; obs_fbdir = 1'bx;
    @(negedge CLK_50MHZ);
    dir[r] = rd;
    addr[8*r +: 8] = a;
    len[LEN_W*r +: LEN_W] = l;
    wdata[8*r +: 8] = w0;
    req[r] = 1'b1;
    cyc = 0;
    while (grant === 2'b00 && cyc < 10) begin
      @(negedge CLK_50MHZ);
      cyc++;
    end
    obs_grant = grant;
    req[r] = 1'b0;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 80) begin
      @(negedge CLK_50MHZ);
      cyc++;
      if (fb_start === 1'b1) begin
        if (obs_starts < 16) begin
          obs_fbaddr[obs_starts]  = fb_addr;
          obs_fbwdata[obs_starts] = fb_wdata;
        end
        obs_fbdir = fb_dir;
        obs_starts++;
      end
      if (byte_ack[r] === 1'b1) begin
        if (obs_acks < 16) obs_rdata[obs_acks] = rdata;
        obs_acks++;
        wdata[8*r +: 8] = w1;
      end
      if (byte_ack[1-r] === 1'b1) obs_other_ack++;
      if (done !== 2'b00) begin
        fin = 1;
        obs_done = done;
        obs_err = err;
        obs_done_at = cyc;
      end
    end
    repeat (3) begin
      @(negedge CLK_50MHZ);
      if (done !== 2'b00) obs_extra_done++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK_50MHZ);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b expected 00", grant); end
    n_cmp++; if (byte_ack !== 2'b00) begin n_bad++; $display("FAIL reset_byte_ack: got %b expected 00", byte_ack); end
    n_cmp++; if (done !== 2'b00) begin n_bad++; $display("FAIL reset_done: got %b expected 00", done); end
    n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b expected 00", err); end
    n_cmp++; if (fb_start !== 1'b0) begin n_bad++; $display("FAIL reset_fb_start: got %b expected 0", fb_start); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    n_cmp++; if (fb_addr !== 8'h00) begin n_bad++; $display("FAIL reset_fb_addr: got %h expected 00", fb_addr); end
    n_cmp++; if (fb_dir !== 1'b1) begin n_bad++; $display("FAIL reset_fb_dir: got %b expected 1", fb_dir); end
    RST = 1'b0;
    repeat (2) @(negedge CLK_50MHZ);
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL idle_grant: got %b expected 00", grant); end
  endtask

  task automatic test_read_burst();
    logic [7:0] exp_a [3];
    logic [7:0] exp_d [3];
    exp_a = '{8'h10, 8'h11, 8'h12};
    exp_d = '{8'hA0, 8'hA1, 8'hA2};
    run_burst(0, 1'b1, 8'h10, 4'd3, 8'h00, 8'h00);
    n_cmp++; if (obs_grant !== 2'b01) begin n_bad++; $display("FAIL rd_grant: got %b expected 01", obs_grant); end
    n_cmp++; if (obs_starts !== 3) begin n_bad++; $display("FAIL rd_starts: got %0d expected 3", obs_starts); end
    n_cmp++; if (obs_fbdir !== 1'b1) begin n_bad++; $display("FAIL rd_fb_dir: got %b expected 1", obs_fbdir); end
    n_cmp++; if (obs_acks !== 3) begin n_bad++; $display("FAIL rd_acks: got %0d expected 3", obs_acks); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (obs_fbaddr[i] !== exp_a[i]) begin n_bad++; $display("FAIL rd_fb_addr[%0d]: got %h expected %h", i, obs_fbaddr[i], exp_a[i]); end
      n_cmp++; if (obs_rdata[i] !== exp_d[i]) begin n_bad++; $display("FAIL rd_rdata[%0d]: got %h expected %h", i, obs_rdata[i], exp_d[i]); end
    end
    n_cmp++; if (obs_done !== 2'b01) begin n_bad++; $display("FAIL rd_done: got %b expected 01", obs_done); end
    n_cmp++; if (obs_err !== 2'b00) begin n_bad++; $display("FAIL rd_err: got %b expected 00", obs_err); end
    n_cmp++; if (obs_extra_done !== 0) begin n_bad++; $display("FAIL rd_single_done: got %0d extra expected 0", obs_extra_done); end
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rd_grant_drop: got %b expected 00", grant); end
  endtask

  task automatic test_write_burst();
    run_burst(1, 1'b0, 8'h40, 4'd2, 8'h55, 8'h66);
    n_cmp++; if (obs_grant !== 2'b10) begin n_bad++; $display("FAIL wr_grant: got %b expected 10", obs_grant); end
    n_cmp++; if (obs_starts !== 2) begin n_bad++; $display("FAIL wr_starts: got %0d expected 2", obs_starts); end
    n_cmp++; if (obs_fbdir !== 1'b0) begin n_bad++; $display("FAIL wr_fb_dir: got %b expected 0", obs_fbdir); end
    n_cmp++; if (obs_fbaddr[0] !== 8'h40) begin n_bad++; $display("FAIL wr_addr0: got %h expected 40", obs_fbaddr[0]); end
    n_cmp++; if (obs_fbwdata[0] !== 8'h55) begin n_bad++; $display("FAIL wr_data0: got %h expected 55", obs_fbwdata[0]); end
    n_cmp++; if (obs_fbaddr[1] !== 8'h41) begin n_bad++; $display("FAIL wr_addr1: got %h expected 41", obs_fbaddr[1]); end
    n_cmp++; if (obs_fbwdata[1] !== 8'h66) begin n_bad++; $display("FAIL wr_data1: got %h expected 66", obs_fbwdata[1]); end
    n_cmp++; if (obs_acks !== 2) begin n_bad++; $display("FAIL wr_acks: got %0d expected 2", obs_acks); end
    n_cmp++; if (obs_other_ack !== 0) begin n_bad++; $display("FAIL wr_other_ack: got %0d expected 0", obs_other_ack); end
    n_cmp++; if (obs_done !== 2'b10) begin n_bad++; $display("FAIL wr_done: got %b expected 10", obs_done); end
    n_cmp++; if (rdata !== 8'hA2) begin n_bad++; $display("FAIL wr_rdata_held: got %h expected A2", rdata); end
  endtask

  task automatic test_tie();
    int cyc;
    @(negedge CLK_50MHZ);
    dir  = 2'b11;
    addr = 16'h0201;
    len  = {4'd1, 4'd1};
    req  = 2'b11;
    cyc = 0;
    while (grant === 2'b00 && cyc < 10) begin @(negedge CLK_50MHZ); cyc++; end
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL tie_first_grant: got %b expected 01", grant); end
    req[0] = 1'b0;
    cyc = 0;
    while (done === 2'b00 && cyc < 40) begin @(negedge CLK_50MHZ); cyc++; end
    n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL tie_first_done: got %b expected 01", done); end
    n_cmp++; if (rdata !== 8'hA1) begin n_bad++; $display("FAIL tie_first_rdata: got %h expected A1", rdata); end
    @(negedge CLK_50MHZ);
    n_cmp++; if (grant !== 2'b10) begin n_bad++; $display("FAIL tie_second_grant: got %b expected 10", grant); end
    req[1] = 1'b0;
    cyc = 0;
    while (done === 2'b00 && cyc < 40) begin @(negedge CLK_50MHZ); cyc++; end
    n_cmp++; if (done !== 2'b10) begin n_bad++; $display("FAIL tie_second_done: got %b expected 10", done); end
    n_cmp++; if (rdata !== 8'hA2) begin n_bad++; $display("FAIL tie_second_rdata: got %h expected A2", rdata); end
    req = 2'b11;
    @(negedge CLK_50MHZ);
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL tie_repeat_grant: got %b expected 01", grant); end
    req = 2'b00;
    cyc = 0;
    while (done === 2'b00 && cyc < 40) begin @(negedge CLK_50MHZ); cyc++; end
    n_cmp++; if (done !== 2'b01) begin n_bad++; $display("FAIL tie_repeat_done: got %b expected 01", done); end
    repeat (3) @(negedge CLK_50MHZ);
  endtask

  task automatic test_wrap_and_zero();
    logic [7:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    run_burst(1, 1'b1, 8'hFE, 4'd4, 8'h00, 8'h00);
    n_cmp++; if (obs_starts !== 4) begin n_bad++; $display("FAIL wrap_starts: got %0d expected 4", obs_starts); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (obs_fbaddr[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_fb_addr[%0d]: got %h expected %h", i, obs_fbaddr[i], exp_a[i]); end
    end
    n_cmp++; if (obs_rdata[3] !== 8'hA1) begin n_bad++; $display("FAIL wrap_last_rdata: got %h expected A1", obs_rdata[3]); end
    n_cmp++; if (obs_done !== 2'b10) begin n_bad++; $display("FAIL wrap_done: got %b expected 10", obs_done); end

    run_burst(0, 1'b1, 8'h80, 4'd0, 8'h00, 8'h00);
    n_cmp++; if (obs_grant !== 2'b01) begin n_bad++; $display("FAIL zero_grant: got %b expected 01", obs_grant); end
    n_cmp++; if (obs_starts !== 0) begin n_bad++; $display("FAIL zero_starts: got %0d expected 0", obs_starts); end
    n_cmp++; if (obs_done !== 2'b01) begin n_bad++; $display("FAIL zero_done: got %b expected 01", obs_done); end
    n_cmp++; if (obs_done_at !== 2) begin n_bad++; $display("FAIL zero_done_latency: got %0d expected 2", obs_done_at); end
    n_cmp++; if (obs_acks !== 0) begin n_bad++; $display("FAIL zero_acks: got %0d expected 0", obs_acks); end
  endtask

  task automatic test_timeout();
    int stray;
    bridge_mode = 2;
    run_burst(0, 1'b1, 8'h20, 4'd2, 8'h00, 8'h00);
    n_cmp++; if (obs_starts !== 1) begin n_bad++; $display("FAIL to_starts: got %0d expected 1", obs_starts); end
    n_cmp++; if (obs_acks !== 0) begin n_bad++; $display("FAIL to_acks: got %0d expected 0", obs_acks); end
    n_cmp++; if (obs_done !== 2'b01) begin n_bad++; $display("FAIL to_done: got %b expected 01", obs_done); end
    n_cmp++; if (obs_err !== 2'b01) begin n_bad++; $display("FAIL to_err: got %b expected 01", obs_err); end
    n_cmp++; if (obs_done_at !== TIMEOUT + 2) begin n_bad++; $display("FAIL to_latency: got %0d expected %0d", obs_done_at, TIMEOUT + 2); end
    stray = 0;
    repeat (8) begin
      @(negedge CLK_50MHZ);
      if (byte_ack !== 2'b00 || grant !== 2'b00 || done !== 2'b00 || fb_start !== 1'b0) stray++;
    end
    n_cmp++; if (stray !== 0) begin n_bad++; $display("FAIL to_late_done_ignored: got %0d stray cycles expected 0", stray); end
    n_cmp++; if (rdata !== 8'hA1) begin n_bad++; $display("FAIL to_rdata_held: got %h expected A1", rdata); end
    bridge_mode = 0;
    run_burst(1, 1'b1, 8'h05, 4'd1, 8'h00, 8'h00);
    n_cmp++; if (obs_rdata[0] !== 8'hA5) begin n_bad++; $display("FAIL to_next_rdata: got %h expected A5", obs_rdata[0]); end
    n_cmp++; if (obs_done !== 2'b10) begin n_bad++; $display("FAIL to_next_done: got %b expected 10", obs_done); end
    n_cmp++; if (obs_err !== 2'b00) begin n_bad++; $display("FAIL to_next_err: got %b expected 00", obs_err); end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    bridge_mode = 1;
    @(negedge CLK_50MHZ);
    dir[0] = 1'b1;
    addr[7:0] = 8'h70;
    len[LEN_W-1:0] = 4'd3;
    req[0] = 1'b1;
    cyc = 0;
    while (grant === 2'b00 && cyc < 10) begin @(negedge CLK_50MHZ); cyc++; end
    req[0] = 1'b0;
    cyc = 0;
    while (fb_start !== 1'b1 && cyc < 10) begin @(negedge CLK_50MHZ); cyc++; end
    n_cmp++; if (fb_addr !== 8'h70) begin n_bad++; $display("FAIL mid_fb_addr_before: got %h expected 70", fb_addr); end
    repeat (2) @(negedge CLK_50MHZ);
    #2 RST = 1'b1;
    #1;
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL mid_rst_grant: got %b expected 00", grant); end
    n_cmp++; if (fb_addr !== 8'h00) begin n_bad++; $display("FAIL mid_rst_fb_addr: got %h expected 00", fb_addr); end
    n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL mid_rst_rdata: got %h expected 00", rdata); end
    n_cmp++; if (fb_dir !== 1'b1) begin n_bad++; $display("FAIL mid_rst_fb_dir: got %b expected 1", fb_dir); end
    n_cmp++; if ({done, err, byte_ack, fb_start} !== 7'b0) begin n_bad++; $display("FAIL mid_rst_pulses: got %b expected 0000000", {done, err, byte_ack, fb_start}); end
    @(negedge CLK_50MHZ);
    RST = 1'b0;
    bridge_mode = 0;
    run_burst(0, 1'b1, 8'h33, 4'd1, 8'h00, 8'h00);
    n_cmp++; if (obs_starts !== 1) begin n_bad++; $display("FAIL mid_after_starts: got %0d expected 1", obs_starts); end
    n_cmp++; if (obs_fbaddr[0] !== 8'h33) begin n_bad++; $display("FAIL mid_after_fb_addr: got %h expected 33", obs_fbaddr[0]); end
    n_cmp++; if (obs_rdata[0] !== 8'hA3) begin n_bad++; $display("FAIL mid_after_rdata: got %h expected A3", obs_rdata[0]); end
    n_cmp++; if (obs_done !== 2'b01) begin n_bad++; $display("FAIL mid_after_done: got %b expected 01", obs_done); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bridge_mode = 0;
    RST   = 1'b1;
    req   = 2'b00;
    dir   = 2'b00;
    addr  = 16'h0000;
    len   = '0;
    wdata = 16'h0000;
    test_reset();
    test_read_burst();
    test_write_burst();
    test_tie();
    test_wrap_and_zero();
    test_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
